digit_scan_ctrl: RTL
====================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 1000, meaning clk cycles each digit is driven (legal >= 1).
REQ-002 Parameter BLANK, default 4, meaning clk cycles of inter-digit blanking (legal >= 1).
REQ-003 Port clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  scan enable.
REQ-006 Port digit_en  input  8  per-digit enable mask; bit i set means digit i is scanned.
REQ-007 Port sel  output  3  registered digit index, feeds the 3-to-8 one-hot decoder input.
REQ-008 Port sel_valid  output  1  registered; high while sel is being driven, gates the decoder output.
REQ-009 Port frame_done  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-010 The FSM SHALL have states IDLE, ACTIVE, BLANK; a digit counter SHALL be sized $clog2(max(PRESCALE,BLANK)+1).
REQ-011 IDLE: if en=1 and digit_en!=0, the next state SHALL be ACTIVE, sel = lowest set bit of digit_en, sel_valid=1, counter=0; otherwise the FSM SHALL stay in IDLE with sel_valid=0.
REQ-012 ACTIVE: the counter SHALL count 0..PRESCALE-1; at PRESCALE-1 the next state SHALL be BLANK, sel_valid=0, sel held, counter=0.
REQ-013 BLANK: the counter SHALL count 0..BLANK-1; at BLANK-1 the next index SHALL be the next set bit of digit_en strictly above sel, wrapping cyclically to the lowest set bit; the next state SHALL be ACTIVE with sel_valid=1.
REQ-014 frame_done SHALL be 1 for exactly the cycle in which sel_valid re-asserts with a next index <= the previous index (wrap); a single-bit mask SHALL pulse frame_done every digit period.
REQ-015 digit_en SHALL be sampled only at selection points (IDLE exit and BLANK end); mask changes mid-ACTIVE or mid-BLANK SHALL not shorten the current period.
REQ-016 If digit_en==0 at a BLANK-end selection point, the next state SHALL be IDLE, sel=0, sel_valid=0, frame_done=0.
REQ-017 en=0 in any state SHALL force IDLE next cycle with sel=0, sel_valid=0, counter=0, frame_done=0; re-enable SHALL restart at the lowest set bit.
REQ-018 Digit periods SHALL be exactly PRESCALE cycles sel_valid high followed by BLANK cycles low; no cycle SHALL be lost at wrap-around.

Reset
REQ-019 reset=1 SHALL, on the next edge, set state=IDLE, counter=0, sel=0, sel_valid=0, frame_done=0, overriding en.
REQ-020 Reset asserted mid-ACTIVE or mid-BLANK SHALL abort the digit; after release the scan SHALL restart per REQ-011.

Configuration
REQ-021 Macro DIGIT_SCAN_BLANK_EN defined: BLANK state and the BLANK parameter SHALL be compiled in as per REQ-012/013.
REQ-022 Macro undefined: no BLANK state; at ACTIVE counter PRESCALE-1 the FSM SHALL select the next index directly, sel_valid SHALL stay 1 while digits remain enabled, the BLANK parameter SHALL be ignored, and frame_done SHALL follow REQ-014.

Structure
REQ-023 Package scan_pkg SHALL hold NUM_DIGITS=8, SEL_W=3, and the FSM state typedef/encoding.
REQ-024 The next-enabled-index search (current index + mask -> next index, wrap flag, none flag) SHALL be one combinational sub-module, scan_next_idx.

Verification (PRESCALE=4, BLANK=2 unless noted)
REQ-025 Reset, en=1, digit_en=8'hFF -> sel_valid rises 1 cycle later; sel 0,1,..,7, each 4 cycles valid + 2 blank; frame_done one pulse per 48 cycles at 7->0.
REQ-026 digit_en=8'b1010_0100 -> sel sequence 2,5,7,2,...; frame_done only on 7->2.
REQ-027 digit_en=8'b0001_0000 -> sel constant 4, sel_valid 4 high/2 low, frame_done every 6 cycles.
REQ-028 en dropped in ACTIVE cycle 2 -> next cycle sel=0, sel_valid=0; en re-asserted with 8'h30 -> sel=4 next cycle.
REQ-029 digit_en set to 0 during BLANK -> IDLE at BLANK end, sel_valid stays 0; reset pulse mid-ACTIVE -> all outputs 0 next cycle.
REQ-030 DIGIT_SCAN_BLANK_EN undefined, digit_en=8'h03 -> sel 0,1,0,... every 4 cycles, sel_valid continuously 1 after start.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants, FSM state encoding and helpers for the digit scan controller.
// DIGIT_SCAN_BLANK_EN adds the inter-digit BLANK state to the encoding.
package scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;

`ifdef DIGIT_SCAN_BLANK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } scan_state_e;
`else
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } scan_state_e;
`endif

  // Index of the lowest set bit; 0 for an empty mask (callers check emptiness separately).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] m);
    lowest_set = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_next_idx.sv
// Combinational search for the next enabled digit strictly above cur_idx,
// wrapping cyclically to the lowest enabled digit.
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]      cur_idx,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      nxt_idx,
  output logic                  wrap,
  output logic                  none
);

  logic [NUM_DIGITS-1:0] above;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_above
    assign above[gi] = mask[gi] && (SEL_W'(gi) > cur_idx);
  end

  // Wrap also covers a single enabled digit selecting itself again.
  always_comb begin
    none    = (mask == '0);
    wrap    = (above == '0);
    nxt_idx = wrap ? lowest_set(mask) : lowest_set(above);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display digit scanner: drives each enabled digit for PRESCALE cycles.
// With DIGIT_SCAN_BLANK_EN defined, BLANK cycles of blanking follow each digit.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic                  frame_done
);

  localparam int CNT_MAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PRESCALE - 1);
`ifdef DIGIT_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK - 1);
`endif

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [SEL_W-1:0] cur_idx;
  logic [SEL_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             nxt_none;

  // From IDLE, searching above the top index yields the lowest enabled digit.
  assign cur_idx = (state_q == ST_IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel_q;

  scan_next_idx u_next (
    .cur_idx (cur_idx),
    .mask    (digit_en),
    .nxt_idx (nxt_idx),
    .wrap    (nxt_wrap),
    .none    (nxt_none)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    sel_valid_d  = sel_valid_q;
    frame_done_d = 1'b0;
    if (!en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      sel_d       = '0;
      sel_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!nxt_none) begin
            state_d     = ST_ACTIVE;
            sel_d       = nxt_idx;
            sel_valid_d = 1'b1;
          end else begin
            sel_d       = '0;
            sel_valid_d = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cnt_q == P_LAST) begin
            cnt_d = '0;
`ifdef DIGIT_SCAN_BLANK_EN
            state_d     = ST_BLANK;
            sel_valid_d = 1'b0;
`else
            if (nxt_none) begin
              state_d     = ST_IDLE;
              sel_d       = '0;
              sel_valid_d = 1'b0;
            end else begin
              sel_d        = nxt_idx;
              sel_valid_d  = 1'b1;
              frame_done_d = nxt_wrap;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef DIGIT_SCAN_BLANK_EN
        ST_BLANK: begin
          if (cnt_q == B_LAST) begin
            cnt_d = '0;
            if (nxt_none) begin
              state_d     = ST_IDLE;
              sel_d       = '0;
              sel_valid_d = 1'b0;
            end else begin
              state_d      = ST_ACTIVE;
              sel_d        = nxt_idx;
              sel_valid_d  = 1'b1;
              frame_done_d = nxt_wrap;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          sel_d       = '0;
          sel_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign frame_done = frame_done_q;

endmodule
